// File: rtl/branch_pc_ctrl.sv
// Branch decision and PC register: resolves conditional branches, jumps and misaligned-target traps.
// Optional feature: define BRANCH_STATS_EN to add the BrCount/BrTakenCount branch statistics outputs.
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ImemReady,
  input  logic        Branch,
  input  logic        Jal,
  input  logic        Jalr,
  input  logic [2:0]  Funct3,
  input  logic        BrEq,
  input  logic        BrLT,
  input  logic [31:0] Target,
  output logic        BrUn,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        PCSel,
  output logic        Trap,
`ifdef BRANCH_STATS_EN
  output logic [31:0] BrCount,
  output logic [31:0] BrTakenCount,
`endif
  output logic [31:0] EPC
);

  typedef enum logic [1:0] {RUN, STALL, TRAP} state_t;

  state_t      state, state_next;
  logic        cond, redir, mis;
  logic [31:0] redir_tgt, pc_next, epc_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cond = 1'b0;
    unique case (Funct3)
      3'b000:         cond = BrEq;
      3'b001:         cond = ~BrEq;
      3'b100, 3'b110: cond = BrLT;
      3'b101, 3'b111: cond = ~BrLT;
      default:        cond = 1'b0;
    endcase
  end

  // funct3[1] separates the unsigned compares (BLTU/BGEU) from the signed ones.
  assign BrUn      = Funct3[1];
  assign redir_tgt = Jalr ? {Target[31:1], 1'b0} : Target;
  assign redir     = ImemReady & ((Branch & cond) | Jal | Jalr);
  assign mis       = redir & (redir_tgt[1:0] != 2'b00);
  assign PCSel     = redir & ~mis;
  assign PCPlus4   = PC + 32'd4;
  assign Trap      = (state == TRAP);

  // Every state evaluates a ready instruction the same way; the state only records stall/trap history.
  always_comb begin
    state_next = state;
    pc_next    = PC;
    epc_next   = EPC;
    if (!ImemReady) begin
      state_next = STALL;
    end else if (mis) begin
      state_next = TRAP;
      pc_next    = TRAP_VEC;
      epc_next   = PC;
    end else begin
      state_next = RUN;
      pc_next    = PCSel ? redir_tgt : PCPlus4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      PC    <= RESET_PC;
      EPC   <= 32'h0;
    end else begin
      state <= state_next;
      PC    <= pc_next;
      EPC   <= epc_next;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      BrCount      <= 32'h0;
      BrTakenCount <= 32'h0;
    end else if (ImemReady & Branch) begin
      BrCount <= BrCount + 32'd1;
      if (cond & ~mis) BrTakenCount <= BrTakenCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Self-checking bench for branch_pc_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_branch_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ImemReady, Branch, Jal, Jalr, BrEq, BrLT;
  logic [2:0]  Funct3;
  logic [31:0] Target;
  logic        BrUn, PCSel, Trap;
  logic [31:0] PC, PCPlus4, EPC;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_trap;

  branch_pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .ImemReady(ImemReady), .Branch(Branch), .Jal(Jal), .Jalr(Jalr),
    .Funct3(Funct3), .BrEq(BrEq), .BrLT(BrLT), .Target(Target), .BrUn(BrUn), .PC(PC),
    .PCPlus4(PCPlus4), .PCSel(PCSel), .Trap(Trap), .EPC(EPC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Branch condition table written straight from the mnemonic meanings.
  function automatic bit taken_of(input int f3, input bit eq, input bit lt);
    case (f3)
      0: return eq;        // BEQ
      1: return !eq;       // BNE
      4, 6: return lt;     // BLT / BLTU
      5, 7: return !lt;    // BGE / BGEU
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit ready, input bit br, input bit jal, input bit jalr,
                      input int f3, input bit eq, input bit lt, input logic [31:0] tgt);
    logic [31:0] t;
    bit c, r, m, unsgn;
    @(negedge clk);
    rst = 0; ImemReady = ready; Branch = br; Jal = jal; Jalr = jalr;
    Funct3 = f3[2:0]; BrEq = eq; BrLT = lt; Target = tgt;
    t     = jalr ? (tgt & 32'hFFFF_FFFE) : tgt;
    c     = taken_of(f3, eq, lt);
    r     = ready && ((br && c) || jal || jalr);
    m     = r && (t % 4 != 0);
    unsgn = (f3 == 2 || f3 == 3 || f3 == 6 || f3 == 7);
    #1;
    check("BrUn", {31'b0, BrUn}, {31'b0, unsgn});
    check("PCSel", {31'b0, PCSel}, {31'b0, r && !m});
    check("PCPlus4", PCPlus4, m_pc + 32'd4);
    @(posedge clk);
    if (!ready) begin
      m_trap = 0;
    end else if (m) begin
      m_epc = m_pc; m_pc = TRAP_VEC; m_trap = 1;
    end else begin
      m_pc = r ? t : m_pc + 32'd4; m_trap = 0;
    end
    #1;
    check("PC", PC, m_pc);
    check("Trap", {31'b0, Trap}, {31'b0, m_trap});
    check("EPC", EPC, m_epc);
  endtask

  task automatic do_reset(input int cycles, input bit ready);
    @(negedge clk);
    rst = 1; ImemReady = ready; Branch = 1; BrEq = 1; Funct3 = 3'b000; Target = 32'h0000_0302;
    Jal = 0; Jalr = 0; BrLT = 0;
    repeat (cycles) @(posedge clk);
    #1;
    m_pc = RESET_PC; m_epc = 32'h0; m_trap = 0;
    check("rst_PC", PC, m_pc);
    check("rst_Trap", {31'b0, Trap}, 32'h0);
    check("rst_EPC", EPC, 32'h0);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; ImemReady = 0; Branch = 0; Jal = 0; Jalr = 0;
    Funct3 = 3'b000; BrEq = 0; BrLT = 0; Target = 32'h0;
    m_pc = RESET_PC; m_epc = 0; m_trap = 0;

    do_reset(2, 1);
    repeat (4) idle();                              // PC 4, 8, C, 10
    step(1, 1, 0, 0, 0, 1, 0, 32'h0000_0040);       // BEQ taken -> 0x40
    step(1, 1, 0, 0, 7, 0, 1, 32'h0000_0080);       // BGEU with lt -> not taken
    step(1, 1, 0, 0, 4, 0, 1, 32'h0000_0080);       // BLT with lt -> taken
    step(1, 0, 0, 1, 0, 0, 0, 32'h0000_0201);       // JALR odd -> 0x200
    step(1, 0, 0, 1, 0, 0, 0, 32'h0000_0202);       // misaligned -> trap
    step(1, 0, 1, 0, 0, 0, 0, 32'h0000_0006);       // trap again from TRAP
    idle();                                         // Trap drops
    repeat (3) step(0, 1, 0, 0, 0, 1, 0, 32'h0000_0300);
    step(1, 1, 0, 0, 0, 1, 0, 32'h0000_0300);       // redirect after stall
    step(1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);       // jump to top of space
    idle();                                         // wraps to 0
    step(1, 1, 1, 1, 2, 1, 1, 32'h0000_0503);       // Jalr wins: 0x502 misaligned
    step(1, 1, 0, 0, 3, 1, 1, 32'h0000_0400);       // funct3 011 never taken
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);               // enter stall
    do_reset(1, 0);                                 // reset during stall
    idle();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      bit rdy;
      if ($urandom_range(0, 49) == 0) begin
        do_reset(1, $urandom_range(0, 1) == 1);
      end else begin
        tgt = $urandom;
        if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
        rdy = ($urandom_range(0, 4) != 0);
        step(rdy, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, tgt);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
